// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed parallel-in / serial-out transmitter.
// Frame, MSB first: start(0), DATA_W data bits, optional even-parity bit, stop(1).
// Each bit is held for CLKS_PER_BIT clocks. ser_out is registered and idles high.
// Optional feature macro: PISO_SERIAL_TX_PARITY_EN. When it is defined, a parity
// state is inserted between DATA and STOP. When it is undefined, DATA goes
// straight to STOP.
module piso_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_frame,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PISO_SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;        // cycles left in the current bit, minus one
    logic [IDX_W-1:0]  idx_q, idx_d;        // data bit currently on the line
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_frame_q, ser_frame_d;
    logic              done_q, done_d;
`ifdef PISO_SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Next-state logic. Line outputs are computed for the state being entered,
    // so that the registered line changes on the same edge as the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        ser_out_d   = ser_out_q;
        ser_frame_d = ser_frame_q;
        done_d      = 1'b0;
`ifdef PISO_SERIAL_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                ser_out_d   = 1'b1;
                ser_frame_d = 1'b0;
                if (in_valid) begin
                    shift_d   = in_data;
`ifdef PISO_SERIAL_TX_PARITY_EN
                    parity_d  = ^in_data;
`endif
                    state_d   = S_START;
                    cnt_d     = CNT_RELOAD;
                    idx_d     = '0;
                    ser_out_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d     = S_DATA;
                    cnt_d       = CNT_RELOAD;
                    ser_out_d   = shift_q[DATA_W-1];
                    ser_frame_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_RELOAD;
                    shift_d = shift_q << 1;
                    if (idx_q == IDX_LAST) begin
                        ser_frame_d = 1'b0;
`ifdef PISO_SERIAL_TX_PARITY_EN
                        state_d     = S_PARITY;
                        ser_out_d   = parity_q;
`else
                        state_d     = S_STOP;
                        ser_out_d   = 1'b1;
`endif
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        ser_out_d = shift_d[DATA_W-1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef PISO_SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_d   = S_STOP;
                    cnt_d     = CNT_RELOAD;
                    ser_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    ser_out_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                ser_out_d   = 1'b1;
                ser_frame_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            ser_out_q   <= 1'b1;
            ser_frame_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PISO_SERIAL_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            ser_out_q   <= ser_out_d;
            ser_frame_q <= ser_frame_d;
            done_q      <= done_d;
`ifdef PISO_SERIAL_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign ser_out   = ser_out_q;
    assign ser_frame = ser_frame_q;
    assign done      = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: random and directed stimulus for piso_serial_tx.
// A queue-based frame model predicts every output cycle; hand-written bit
// patterns pin the model for a few directed words. A second instance covers
// DATA_W=4, CLKS_PER_BIT=1.
module tb_piso_serial_tx;

`ifdef PISO_SERIAL_TX_PARITY_EN
    localparam int NB  = 11;
    localparam int NB1 = 7;
`else
    localparam int NB  = 10;
    localparam int NB1 = 6;
`endif
    localparam int CPB    = 4;
    localparam int FRAME0 = NB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, ser_out, ser_frame, busy, done;
    logic [3:0] in_data1;
    logic       in_valid1;
    logic       in_ready1, ser_out1, ser_frame1, busy1, done1;

    always #5 clk = ~clk;

    piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_frame(ser_frame),
        .busy(busy), .done(done)
    );

    piso_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .ser_out(ser_out1), .ser_frame(ser_frame1),
        .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic so;
        logic fr;
        logic dn;
        logic rdy;
    } exp_t;

    exp_t q[$];
    int   since_acc = 0;
    int   since1 = 100;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    bit   lit_on = 1'b0;
    logic [NB-1:0]  lit_pat = '0;
    logic [NB1-1:0] pat1;
    logic [NB-1:0]  p_a5, p_a4, p_01, p_3c, p_c3;

    function automatic exp_t mk(logic so, logic fr, logic dn, logic rdy);
        exp_t e;
        e.so = so; e.fr = fr; e.dn = dn; e.rdy = rdy;
        return e;
    endfunction

    // Expand one accepted word into its per-cycle line picture.
    function automatic void push_frame(logic [7:0] w);
        for (int k = 0; k < CPB; k++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        for (int b = 7; b >= 0; b--)
            for (int k = 0; k < CPB; k++) q.push_back(mk(w[b], 1'b1, 1'b0, 1'b0));
`ifdef PISO_SERIAL_TX_PARITY_EN
        for (int k = 0; k < CPB; k++) q.push_back(mk(^w, 1'b0, 1'b0, 1'b0));
`endif
        for (int k = 0; k < CPB; k++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
        end
    endtask

    // Model: advance one cycle per edge, starting a new frame on an accept.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            since_acc <= 0;
        end else begin
            exp_t c;
            c = (q.size() > 0) ? q[0] : mk(1'b1, 1'b0, 1'b0, 1'b1);
            if (q.size() > 0) void'(q.pop_front());
            if (c.rdy && in_valid) begin
                push_frame(in_data);
                since_acc <= 1;
            end else if (since_acc < 10000) begin
                since_acc <= since_acc + 1;
            end
        end
    end

    // Cycle position of the narrow instance relative to its single request.
    always @(posedge clk) begin
        if (in_valid1) since1 <= 1;
        else if (since1 < 100) since1 <= since1 + 1;
    end

    // Compare process: all checks happen on the falling edge.
    always @(negedge clk) begin
        exp_t c;
        c = (q.size() > 0) ? q[0] : mk(1'b1, 1'b0, 1'b0, 1'b1);
        if (chk_en) begin
            chk("ser_out", ser_out, c.so);
            chk("ser_frame", ser_frame, c.fr);
            chk("done", done, c.dn);
            chk("in_ready", in_ready, c.rdy);
            chk("busy", busy, ~c.rdy);
            if (rst) begin
                chk("rst_ser_out", ser_out, 1'b1);
                chk("rst_busy", busy, 1'b0);
            end
            if (lit_on && since_acc >= 1 && since_acc <= FRAME0) begin
                chk("lit_bit", ser_out, lit_pat[NB-1-(since_acc-1)/CPB]);
                chk("lit_frame", ser_frame, (since_acc > CPB && since_acc <= 9*CPB));
                chk("lit_busy", busy, 1'b1);
            end
            if (lit_on && since_acc == FRAME0 + 1) begin
                chk("lit_done", done, 1'b1);
                chk("lit_gap_line", ser_out, 1'b1);
                chk("lit_ready", in_ready, 1'b1);
            end
            if (since1 >= 1 && since1 <= NB1) begin
                chk("d1_bit", ser_out1, pat1[NB1-since1]);
                chk("d1_frame", ser_frame1, (since1 >= 2 && since1 <= 5));
                chk("d1_done", done1, 1'b0);
                chk("d1_busy", busy1, 1'b1);
            end else if (since1 == NB1 + 1) begin
                chk("d1_done", done1, 1'b1);
                chk("d1_ready", in_ready1, 1'b1);
            end else begin
                chk("d1_idle_line", ser_out1, 1'b1);
                chk("d1_idle_ready", in_ready1, 1'b1);
                chk("d1_idle_done", done1, 1'b0);
            end
        end
    end

    task automatic send(input logic [7:0] w, input logic [NB-1:0] p, input bit lit);
        lit_on   = lit;
        lit_pat  = p;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (FRAME0 + 3) @(negedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    initial begin
`ifdef PISO_SERIAL_TX_PARITY_EN
        p_a5 = 11'b01010010101;
        p_a4 = 11'b01010010011;
        p_01 = 11'b00000000111;
        p_3c = 11'b00011110001;
        p_c3 = 11'b01100001101;
        pat1 = 7'b0100101;
`else
        p_a5 = 10'b0101001011;
        p_a4 = 10'b0101001001;
        p_01 = 10'b0000000011;
        p_3c = 10'b0001111001;
        p_c3 = 10'b0110000111;
        pat1 = 6'b010011;
`endif
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        in_valid1 = 1'b0; in_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // quiet line after reset
        repeat (10) @(negedge clk);
        #1;

        send(8'hA5, p_a5, 1'b1);
        send(8'hA4, p_a4, 1'b1);

        // back-to-back: second word taken in the done cycle of the first
        lit_on = 1'b1; lit_pat = p_3c;
        in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk); #1;
        in_data = 8'hC3;
        for (int i = 1; i <= FRAME0 + 1; i++) begin
            @(negedge clk); #1;
            if (i == FRAME0) lit_pat = p_c3;
            if (i == FRAME0 + 1) in_valid = 1'b0;
        end
        repeat (FRAME0 + 3) @(negedge clk);
        #1;
        lit_on = 1'b0;

        // reset pulse during data bit 3 of 0xFF, then a clean 0x01
        in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk); #1;
        in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        send(8'h01, p_01, 1'b1);

        // narrow instance: one-cycle bits
        in_valid1 = 1'b1; in_data1 = 4'h9;
        @(negedge clk); #1;
        in_valid1 = 1'b0; in_data1 = 4'h6;
        repeat (NB1 + 4) @(negedge clk);
        #1;

        // random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 499) == 0);
            @(negedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (FRAME0 + 5) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
